// File: rtl/instr_prefetch_if.sv
// Prefetch queue bundle: memory-side fetch port plus decoder-side window/pop port.
// Latency: n/a (signal bundle only).
// Backpressure: n/a; bus_grant/mem_ack and pop_n throttle the two sides.
interface instr_prefetch_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4
);
   localparam int CW = $clog2(DEPTH + 1);

   logic                  bus_grant;
   logic                  mem_req;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_ack;
   logic [DATA_WIDTH-1:0] mem_data;
   logic                  flush;
   logic [ADDR_WIDTH-1:0] flush_pc;
   logic [DATA_WIDTH-1:0] out_b0;
   logic [DATA_WIDTH-1:0] out_b1;
   logic [DATA_WIDTH-1:0] out_b2;
   logic [ADDR_WIDTH-1:0] out_pc;
   logic [CW-1:0]         count;
   logic [1:0]            pop_n;
   logic                  err;

   // prefetch unit side
   modport master (
      input  bus_grant, mem_ack, mem_data, flush, flush_pc, pop_n,
      output mem_req, mem_addr, out_b0, out_b1, out_b2, out_pc, count, err
   );

   // memory + decoder side
   modport slave (
      output bus_grant, mem_ack, mem_data, flush, flush_pc, pop_n,
      input  mem_req, mem_addr, out_b0, out_b1, out_b2, out_pc, count, err
   );
endinterface

// File: rtl/instr_prefetch.sv
// Instruction prefetch queue: streams sequential bytes into a circular buffer, exposes a 3-byte head window.
// Latency: byte acked in cycle n is visible in the window in cycle n+1; flush takes effect on the next edge.
// Backpressure: fetch requests stop while the registered count is full; pops beyond count are clamped and flag err.
module instr_prefetch #(
   parameter int                    ADDR_WIDTH = 16,
   parameter int                    DATA_WIDTH = 8,
   parameter int                    DEPTH      = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 16'h0000
) (
   input logic               clk,
   input logic               reset,
   instr_prefetch_if.master  pif
);
   localparam int            PW      = $clog2(DEPTH);
   localparam int            CW      = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [DATA_WIDTH-1:0] buf_mem [DEPTH];
   logic [PW-1:0]         rd_ptr;
   logic [PW-1:0]         wr_ptr;
   logic [CW-1:0]         cnt;
   logic [ADDR_WIDTH-1:0] fpc;
   logic [ADDR_WIDTH-1:0] hpc;
   logic                  err_q;

   logic                  req;
   logic                  push;
   logic [CW-1:0]         pop_w;
   logic                  over;
   logic [CW-1:0]         eff;
   logic [DATA_WIDTH-1:0] win [3];

   // Request only on free space judged from the registered count; a same-cycle pop never frees a slot.
   always_comb begin
      req   = pif.bus_grant && !pif.flush && !reset && (cnt < DEPTH_C);
      push  = req && pif.mem_ack;
      pop_w = {{(CW-2){1'b0}}, pif.pop_n};
      over  = pop_w > cnt;
      eff   = over ? cnt : pop_w;
   end

   assign pif.mem_req  = req;
   assign pif.mem_addr = fpc;

   // Head window: entries beyond the valid count read as zero so stale buffer data never leaks out.
   always_comb begin
      for (int k = 0; k < 3; k++) begin
         win[k] = '0;
         if (CW'(k) < cnt) begin
            win[k] = buf_mem[rd_ptr + PW'(k)];
         end
      end
   end

   assign pif.out_b0 = win[0];
   assign pif.out_b1 = win[1];
   assign pif.out_b2 = win[2];
   assign pif.out_pc = hpc;
   assign pif.count  = cnt;
   assign pif.err    = err_q;

   // Buffer storage: write the returning byte at the tail; a flush cycle discards it.
   always_ff @(posedge clk) begin
      if (push && !pif.flush) begin
         buf_mem[wr_ptr] <= pif.mem_data;
      end
   end

   // Pointers, count and addresses: flush overrides any push/pop; hpc + cnt tracks fpc throughout.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
         fpc    <= RESET_PC;
         hpc    <= RESET_PC;
      end else if (pif.flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
         fpc    <= pif.flush_pc;
         hpc    <= pif.flush_pc;
      end else begin
         rd_ptr <= rd_ptr + PW'(eff);
         hpc    <= hpc + ADDR_WIDTH'(eff);
         cnt    <= cnt + CW'(push) - eff;
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
            fpc    <= fpc + 1'b1;
         end
      end
   end

   // Sticky underflow flag; the pop_n of a flush cycle is ignored.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_q <= 1'b0;
      end else if (!pif.flush && over) begin
         err_q <= 1'b1;
      end
   end
endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch: cycle table plus hand-written backpressure and reset sequences.
// Latency: inputs driven at negedge, outputs sampled 1 time unit later (pre-edge state).
// Backpressure: exercised through bus_grant toggling and delayed mem_ack.
module tb_instr_prefetch;
   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   instr_prefetch_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .DEPTH(4)) pif ();

   instr_prefetch #(
      .ADDR_WIDTH(16), .DATA_WIDTH(8), .DEPTH(4), .RESET_PC(16'h0600)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .pif   (pif)
   );

   // memory returns the low byte of the requested address
   assign pif.mem_data = pif.mem_addr[7:0];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        g;
      logic        a;
      logic        f;
      logic [15:0] fpc;
      logic [1:0]  pop;
      logic        req;
      logic [15:0] addr;
      logic [2:0]  cnt;
      logic [7:0]  b0;
      logic [7:0]  b1;
      logic [7:0]  b2;
      logic [15:0] opc;
      logic        e;
   } vec_t;

   vec_t tv [23];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic g, input logic a, input logic f,
                        input logic [15:0] fp, input logic [1:0] pop);
      pif.bus_grant = g;
      pif.mem_ack   = a;
      pif.flush     = f;
      pif.flush_pc  = fp;
      pif.pop_n     = pop;
   endtask

   initial begin
      int pushes;
      n_cmp = 0;
      n_err = 0;
      //          g  a  f  flush_pc  pop  req addr     cnt b0     b1     b2     out_pc   err
      tv[0]  = '{0, 0, 0, 16'h0000, 2'd0, 0, 16'h0600, 3'd0, 8'h00, 8'h00, 8'h00, 16'h0600, 0};
      tv[1]  = '{1, 1, 0, 16'h0000, 2'd0, 1, 16'h0600, 3'd0, 8'h00, 8'h00, 8'h00, 16'h0600, 0};
      tv[2]  = '{1, 1, 0, 16'h0000, 2'd0, 1, 16'h0601, 3'd1, 8'h00, 8'h00, 8'h00, 16'h0600, 0};
      tv[3]  = '{1, 1, 0, 16'h0000, 2'd0, 1, 16'h0602, 3'd2, 8'h00, 8'h01, 8'h00, 16'h0600, 0};
      tv[4]  = '{1, 1, 0, 16'h0000, 2'd0, 1, 16'h0603, 3'd3, 8'h00, 8'h01, 8'h02, 16'h0600, 0};
      tv[5]  = '{1, 1, 0, 16'h0000, 2'd3, 0, 16'h0604, 3'd4, 8'h00, 8'h01, 8'h02, 16'h0600, 0};
      tv[6]  = '{1, 1, 0, 16'h0000, 2'd1, 1, 16'h0604, 3'd1, 8'h03, 8'h00, 8'h00, 16'h0603, 0};
      tv[7]  = '{1, 1, 0, 16'h0000, 2'd0, 1, 16'h0605, 3'd1, 8'h04, 8'h00, 8'h00, 16'h0604, 0};
      tv[8]  = '{1, 1, 0, 16'h0000, 2'd2, 1, 16'h0606, 3'd2, 8'h04, 8'h05, 8'h00, 16'h0604, 0};
      tv[9]  = '{0, 0, 0, 16'h0000, 2'd0, 0, 16'h0607, 3'd1, 8'h06, 8'h00, 8'h00, 16'h0606, 0};
      // flush collides with ack and an over-count pop
      tv[10] = '{1, 1, 1, 16'h1234, 2'd2, 0, 16'h0607, 3'd1, 8'h06, 8'h00, 8'h00, 16'h0606, 0};
      tv[11] = '{0, 0, 0, 16'h0000, 2'd0, 0, 16'h1234, 3'd0, 8'h00, 8'h00, 8'h00, 16'h1234, 0};
      // address wrap-around
      tv[12] = '{0, 0, 1, 16'hFFFE, 2'd0, 0, 16'h1234, 3'd0, 8'h00, 8'h00, 8'h00, 16'h1234, 0};
      tv[13] = '{1, 1, 0, 16'h0000, 2'd0, 1, 16'hFFFE, 3'd0, 8'h00, 8'h00, 8'h00, 16'hFFFE, 0};
      tv[14] = '{1, 1, 0, 16'h0000, 2'd0, 1, 16'hFFFF, 3'd1, 8'hFE, 8'h00, 8'h00, 16'hFFFE, 0};
      tv[15] = '{1, 1, 0, 16'h0000, 2'd0, 1, 16'h0000, 3'd2, 8'hFE, 8'hFF, 8'h00, 16'hFFFE, 0};
      tv[16] = '{1, 1, 0, 16'h0000, 2'd0, 1, 16'h0001, 3'd3, 8'hFE, 8'hFF, 8'h00, 16'hFFFE, 0};
      tv[17] = '{1, 1, 0, 16'h0000, 2'd2, 0, 16'h0002, 3'd4, 8'hFE, 8'hFF, 8'h00, 16'hFFFE, 0};
      tv[18] = '{0, 0, 0, 16'h0000, 2'd1, 0, 16'h0002, 3'd2, 8'h00, 8'h01, 8'h00, 16'h0000, 0};
      // underflow, then sticky err through a flush
      tv[19] = '{0, 0, 0, 16'h0000, 2'd3, 0, 16'h0002, 3'd1, 8'h01, 8'h00, 8'h00, 16'h0001, 0};
      tv[20] = '{0, 0, 1, 16'h0100, 2'd0, 0, 16'h0002, 3'd0, 8'h00, 8'h00, 8'h00, 16'h0002, 1};
      tv[21] = '{0, 0, 0, 16'h0000, 2'd0, 0, 16'h0100, 3'd0, 8'h00, 8'h00, 8'h00, 16'h0100, 1};
      tv[22] = '{0, 0, 0, 16'h0000, 2'd0, 0, 16'h0100, 3'd0, 8'h00, 8'h00, 8'h00, 16'h0100, 1};

      reset = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 16'h0000, 2'd0);
      #1;
      chk("req_in_reset", {31'd0, pif.mem_req}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 23; i++) begin
         if (i != 0) @(negedge clk);
         drive(tv[i].g, tv[i].a, tv[i].f, tv[i].fpc, tv[i].pop);
         #1;
         chk($sformatf("v%0d_req", i),  {31'd0, pif.mem_req}, {31'd0, tv[i].req});
         chk($sformatf("v%0d_addr", i), {16'd0, pif.mem_addr}, {16'd0, tv[i].addr});
         chk($sformatf("v%0d_cnt", i),  {29'd0, pif.count}, {29'd0, tv[i].cnt});
         chk($sformatf("v%0d_b0", i),   {24'd0, pif.out_b0}, {24'd0, tv[i].b0});
         chk($sformatf("v%0d_b1", i),   {24'd0, pif.out_b1}, {24'd0, tv[i].b1});
         chk($sformatf("v%0d_b2", i),   {24'd0, pif.out_b2}, {24'd0, tv[i].b2});
         chk($sformatf("v%0d_pc", i),   {16'd0, pif.out_pc}, {16'd0, tv[i].opc});
         chk($sformatf("v%0d_err", i),  {31'd0, pif.err}, {31'd0, tv[i].e});
         chk($sformatf("v%0d_inv", i),  {16'd0, pif.out_pc + 16'(pif.count)}, {16'd0, pif.mem_addr});
      end

      // delayed ack: address held, nothing pushed for 3 cycles
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive(1'b1, 1'b0, 1'b0, 16'h0000, 2'd0);
         #1;
         chk("dly_req", {31'd0, pif.mem_req}, 32'd1);
         chk("dly_addr", {16'd0, pif.mem_addr}, 32'h0100);
         chk("dly_cnt", {29'd0, pif.count}, 32'd0);
      end
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b0, 16'h0000, 2'd0);
      pushes = 1;

      // grant toggling with ack held high
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         drive(i[0], 1'b1, 1'b0, 16'h0000, 2'd0);
         #1;
         chk("tog_req", {31'd0, pif.mem_req}, {31'd0, i[0]});
         chk("tog_addr", {16'd0, pif.mem_addr}, 32'h0100 + 32'(pushes));
         chk("tog_cnt", {29'd0, pif.count}, 32'(pushes));
         if (i[0]) pushes++;
      end
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 2'd0);
      #1;
      chk("tog_fin_cnt", {29'd0, pif.count}, 32'd4);
      chk("tog_fin_b0", {24'd0, pif.out_b0}, 32'h00);
      chk("tog_fin_b1", {24'd0, pif.out_b1}, 32'h01);
      chk("tog_fin_b2", {24'd0, pif.out_b2}, 32'h02);
      chk("tog_fin_addr", {16'd0, pif.mem_addr}, 32'h0104);
      chk("tog_fin_pc", {16'd0, pif.out_pc}, 32'h0100);

      // reset mid-transfer drops everything
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b0, 16'h0000, 2'd1);
      reset = 1'b1;
      #1;
      chk("rst_req", {31'd0, pif.mem_req}, 32'd0);
      chk("rst_cnt", {29'd0, pif.count}, 32'd0);
      chk("rst_err", {31'd0, pif.err}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 2'd0);
      #1;
      chk("rst_addr", {16'd0, pif.mem_addr}, 32'h0600);
      chk("rst_pc", {16'd0, pif.out_pc}, 32'h0600);
      chk("rst_b0", {24'd0, pif.out_b0}, 32'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
